// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage
//
// Second pipeline stage of the brisc core. Holds the IF/ID pipeline
// register, decodes the supported instruction subset, owns the 32-entry
// architectural register file and reads both source operands from it.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous, active-low reset
//   stall_decode   hold IF/ID contents
//   flush_decode   replace IF/ID contents with a bubble (wins over stall)
//   valid_in       fetch presents a valid instruction
//   instr_in       instruction from fetch
//   pc_in          PC of instr_in
//   wb_en/wb_rd/wb_data   register-file write port from the last stage
//   valid_out      decoded instruction valid
//   pc_out         PC of decoded instruction
//   rs1/rs2/rd     register indices (rd is meaningful only with reg_write)
//   rs1_data/rs2_data     operand values
//   imm            sign-extended immediate
//   alu_op         0=ADD, 1=SUB, 2=MUL
//   alu_src_imm    operand B is imm
//   reg_write, mem_read, mem_write, mem_byte, is_branch, is_jump  control
//   illegal        valid instruction with unsupported encoding
//
// Build option:
//   BRISC_RF_BYPASS_EN  when defined, a same-cycle write-back to rs1/rs2 is
//                       forwarded combinationally onto rs1_data/rs2_data.
//                       When undefined, reads return the stored value only.
//
// Valid semantics: valid_in qualifies instr_in/pc_in in the cycle they are
// captured; valid_out qualifies every decoded output. While valid_out is 0
// all control outputs are driven to 0, so downstream stages may consume
// them without further qualification. There is no ready: back-pressure is
// applied by the hazard logic through stall_decode.
// ---------------------------------------------------------------------------
module decode_stage #(
    parameter int               XLEN     = 32,
    parameter int               NUM_REGS = 32,
    parameter logic [XLEN-1:0]  PC_BOOT  = 32'h0000_1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall_decode,
    input  logic              flush_decode,
    input  logic              valid_in,
    input  logic [31:0]       instr_in,
    input  logic [XLEN-1:0]   pc_in,
    input  logic              wb_en,
    input  logic [4:0]        wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    output logic              valid_out,
    output logic [XLEN-1:0]   pc_out,
    output logic [4:0]        rs1,
    output logic [4:0]        rs2,
    output logic [4:0]        rd,
    output logic [XLEN-1:0]   rs1_data,
    output logic [XLEN-1:0]   rs2_data,
    output logic [XLEN-1:0]   imm,
    output logic [1:0]        alu_op,
    output logic              alu_src_imm,
    output logic              reg_write,
    output logic              mem_read,
    output logic              mem_write,
    output logic              mem_byte,
    output logic              is_branch,
    output logic              is_jump,
    output logic              illegal
);

    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;  // addi x0,x0,0

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_MUL = 2'd2;

    // -----------------------------------------------------------------------
    // IF/ID pipeline register
    // -----------------------------------------------------------------------
    logic              valid_q, valid_d;
    logic [31:0]       instr_q, instr_d;
    logic [XLEN-1:0]   pc_q,    pc_d;

    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (flush_decode) begin
            // Bubble keeps the old PC; only the instruction is squashed.
            valid_d = 1'b0;
            instr_d = INSTR_NOP;
        end else if (!stall_decode) begin
            valid_d = valid_in;
            instr_d = instr_in;
            pc_d    = pc_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            instr_q <= INSTR_NOP;
            pc_q    <= PC_BOOT;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    // -----------------------------------------------------------------------
    // Register file. Entry 0 is forced to zero so x0 reads need no special
    // case; writes are independent of stall/flush.
    // -----------------------------------------------------------------------
    logic [XLEN-1:0] rf_q [NUM_REGS];
    logic [XLEN-1:0] rf_d [NUM_REGS];

    always_comb begin
        rf_d = rf_q;
        if (wb_en && (wb_rd != 5'd0)) begin
            rf_d[wb_rd] = wb_data;
        end
        rf_d[0] = '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            rf_q <= rf_d;
        end
    end

    // -----------------------------------------------------------------------
    // Field extraction and operand read
    // -----------------------------------------------------------------------
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = instr_q[6:0];
    assign funct3 = instr_q[14:12];
    assign funct7 = instr_q[31:25];
    assign rs1    = instr_q[19:15];
    assign rs2    = instr_q[24:20];
    assign rd     = instr_q[11:7];
    assign pc_out = pc_q;

    always_comb begin
        rs1_data = rf_q[rs1];
        rs2_data = rf_q[rs2];
`ifdef BRISC_RF_BYPASS_EN
        if (wb_en && (wb_rd != 5'd0) && (wb_rd == rs1)) begin
            rs1_data = wb_data;
        end
        if (wb_en && (wb_rd != 5'd0) && (wb_rd == rs2)) begin
            rs2_data = wb_data;
        end
`endif
    end

    // -----------------------------------------------------------------------
    // Decode
    // -----------------------------------------------------------------------
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j;

    assign imm_i = {{(XLEN-12){instr_q[31]}}, instr_q[31:20]};
    assign imm_s = {{(XLEN-12){instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
    assign imm_b = {{(XLEN-13){instr_q[31]}}, instr_q[31], instr_q[7],
                    instr_q[30:25], instr_q[11:8], 1'b0};
    assign imm_j = {{(XLEN-21){instr_q[31]}}, instr_q[31], instr_q[19:12],
                    instr_q[20], instr_q[30:21], 1'b0};

    logic [XLEN-1:0] dec_imm;
    logic [1:0]      dec_alu_op;
    logic            dec_src_imm, dec_reg_write, dec_mem_read, dec_mem_write;
    logic            dec_mem_byte, dec_is_branch, dec_is_jump, dec_illegal;

    always_comb begin
        dec_imm       = '0;
        dec_alu_op    = ALU_ADD;
        dec_src_imm   = 1'b0;
        dec_reg_write = 1'b0;
        dec_mem_read  = 1'b0;
        dec_mem_write = 1'b0;
        dec_mem_byte  = 1'b0;
        dec_is_branch = 1'b0;
        dec_is_jump   = 1'b0;
        dec_illegal   = 1'b0;
        case (opcode)
            OP_R: begin
                if (funct3 == 3'b000 && funct7 == 7'b0000000) begin
                    dec_reg_write = 1'b1;
                end else if (funct3 == 3'b000 && funct7 == 7'b0100000) begin
                    dec_alu_op    = ALU_SUB;
                    dec_reg_write = 1'b1;
                end else if (funct3 == 3'b000 && funct7 == 7'b0000001) begin
                    dec_alu_op    = ALU_MUL;
                    dec_reg_write = 1'b1;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            OP_IMM: begin
                if (funct3 == 3'b000) begin
                    dec_imm       = imm_i;
                    dec_src_imm   = 1'b1;
                    dec_reg_write = 1'b1;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            OP_LOAD: begin
                if (funct3 == 3'b000 || funct3 == 3'b010) begin
                    dec_imm       = imm_i;
                    dec_src_imm   = 1'b1;
                    dec_reg_write = 1'b1;
                    dec_mem_read  = 1'b1;
                    dec_mem_byte  = (funct3 == 3'b000);
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            OP_STORE: begin
                if (funct3 == 3'b000 || funct3 == 3'b010) begin
                    dec_imm       = imm_s;
                    dec_src_imm   = 1'b1;
                    dec_mem_write = 1'b1;
                    dec_mem_byte  = (funct3 == 3'b000);
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            OP_BRANCH: begin
                if (funct3 == 3'b000) begin
                    // BEQ compares by subtraction in execute.
                    dec_imm       = imm_b;
                    dec_alu_op    = ALU_SUB;
                    dec_is_branch = 1'b1;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            OP_JAL: begin
                dec_imm       = imm_j;
                dec_is_jump   = 1'b1;
                dec_reg_write = 1'b1;
            end
            default: begin
                dec_illegal = 1'b1;
            end
        endcase
    end

    // A bubble must never look like a real instruction to execute.
    assign valid_out   = valid_q;
    assign imm         = dec_imm;
    assign alu_op      = valid_q ? dec_alu_op : ALU_ADD;
    assign alu_src_imm = valid_q & dec_src_imm;
    assign reg_write   = valid_q & dec_reg_write;
    assign mem_read    = valid_q & dec_mem_read;
    assign mem_write   = valid_q & dec_mem_write;
    assign mem_byte    = valid_q & dec_mem_byte;
    assign is_branch   = valid_q & dec_is_branch;
    assign is_jump     = valid_q & dec_is_jump;
    assign illegal     = valid_q & dec_illegal;

endmodule

// File: tb/tb_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_decode_stage
//
// Self-checking bench for decode_stage: directed scenarios followed by
// randomized traffic, all compared against a behavioural model of the
// pipeline register, register file and instruction-set decode.
// ---------------------------------------------------------------------------
module tb_decode_stage;

    localparam logic [31:0] PC_BOOT = 32'h0000_1000;
    localparam logic [31:0] NOP     = 32'h0000_0013;

    // ---------------------------------------------------------------- clock/reset
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    always #5 clk = ~clk;

    logic        stall_decode = 1'b0, flush_decode = 1'b0, valid_in = 1'b0;
    logic [31:0] instr_in = NOP, pc_in = PC_BOOT;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_rd = 5'd0;
    logic [31:0] wb_data = 32'd0;

    logic        valid_out, alu_src_imm, reg_write, mem_read, mem_write;
    logic        mem_byte, is_branch, is_jump, illegal;
    logic [31:0] pc_out, rs1_data, rs2_data, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [1:0]  alu_op;

    decode_stage dut (
        .clk(clk), .reset(reset),
        .stall_decode(stall_decode), .flush_decode(flush_decode),
        .valid_in(valid_in), .instr_in(instr_in), .pc_in(pc_in),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .valid_out(valid_out), .pc_out(pc_out),
        .rs1(rs1), .rs2(rs2), .rd(rd),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
        .alu_op(alu_op), .alu_src_imm(alu_src_imm),
        .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
        .mem_byte(mem_byte), .is_branch(is_branch), .is_jump(is_jump),
        .illegal(illegal)
    );

    // ---------------------------------------------------------------- scoreboard
    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- reference model
    bit          m_valid;
    logic [31:0] m_instr, m_pc;
    logic [31:0] m_rf [32];

    function automatic void model_reset();
        m_valid = 1'b0;
        m_instr = NOP;
        m_pc    = PC_BOOT;
        for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            model_reset();
        end else begin
            if (flush_decode) begin
                m_valid = 1'b0;
                m_instr = NOP;
            end else if (!stall_decode) begin
                m_valid = valid_in;
                m_instr = instr_in;
                m_pc    = pc_in;
            end
            if (wb_en && wb_rd != 0) m_rf[wb_rd] = wb_data;
        end
    end

    typedef struct packed {
        logic        legal;
        logic        has_imm;
        logic [1:0]  alu_op;
        logic        src_imm;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        mem_byte;
        logic        is_branch;
        logic        is_jump;
        logic [31:0] imm;
    } exp_t;

    // Immediates are rebuilt arithmetically from the signed instruction word.
    function automatic exp_t model_decode(input logic [31:0] ins);
        exp_t e;
        int   s, sgn;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        op  = ins[6:0];
        f3  = ins[14:12];
        f7  = ins[31:25];
        s   = $signed(ins);
        sgn = s >>> 31;
        e = '0;
        e.legal = 1'b1;
        if (op == 7'h33 && f3 == 0 && f7 == 7'h00) begin
            e.reg_write = 1'b1;
        end else if (op == 7'h33 && f3 == 0 && f7 == 7'h20) begin
            e.alu_op = 2'd1; e.reg_write = 1'b1;
        end else if (op == 7'h33 && f3 == 0 && f7 == 7'h01) begin
            e.alu_op = 2'd2; e.reg_write = 1'b1;
        end else if (op == 7'h13 && f3 == 0) begin
            e.has_imm = 1'b1; e.imm = 32'(s >>> 20);
            e.src_imm = 1'b1; e.reg_write = 1'b1;
        end else if (op == 7'h03 && (f3 == 0 || f3 == 2)) begin
            e.has_imm = 1'b1; e.imm = 32'(s >>> 20);
            e.src_imm = 1'b1; e.reg_write = 1'b1; e.mem_read = 1'b1;
            e.mem_byte = (f3 == 0);
        end else if (op == 7'h23 && (f3 == 0 || f3 == 2)) begin
            e.has_imm = 1'b1;
            e.imm = 32'(((s >>> 25) << 5) | int'(ins[11:7]));
            e.src_imm = 1'b1; e.mem_write = 1'b1; e.mem_byte = (f3 == 0);
        end else if (op == 7'h63 && f3 == 0) begin
            e.has_imm = 1'b1;
            e.imm = 32'((sgn << 12) | (int'(ins[7]) << 11)
                        | (int'(ins[30:25]) << 5) | (int'(ins[11:8]) << 1));
            e.alu_op = 2'd1; e.is_branch = 1'b1;
        end else if (op == 7'h6f) begin
            e.has_imm = 1'b1;
            e.imm = 32'((sgn << 20) | (int'(ins[19:12]) << 12)
                        | (int'(ins[20]) << 11) | (int'(ins[30:21]) << 1));
            e.is_jump = 1'b1; e.reg_write = 1'b1;
        end else begin
            e.legal = 1'b0;
        end
        return e;
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] idx);
        if (idx == 0) return 32'd0;
`ifdef BRISC_RF_BYPASS_EN
        if (wb_en && wb_rd == idx) return wb_data;
`endif
        return m_rf[idx];
    endfunction

    task automatic check_outputs();
        exp_t e;
        e = model_decode(m_instr);
        check_eq("valid_out", 32'(valid_out), 32'(m_valid));
        check_eq("pc_out",    pc_out, m_pc);
        check_eq("rs1",       32'(rs1), 32'(m_instr[19:15]));
        check_eq("rs2",       32'(rs2), 32'(m_instr[24:20]));
        check_eq("rd",        32'(rd),  32'(m_instr[11:7]));
        check_eq("rs1_data",  rs1_data, model_read(m_instr[19:15]));
        check_eq("rs2_data",  rs2_data, model_read(m_instr[24:20]));
        if (m_valid) begin
            check_eq("illegal",   32'(illegal),   32'(!e.legal));
            check_eq("reg_write", 32'(reg_write), 32'(e.reg_write));
            check_eq("mem_read",  32'(mem_read),  32'(e.mem_read));
            check_eq("mem_write", 32'(mem_write), 32'(e.mem_write));
            check_eq("mem_byte",  32'(mem_byte),  32'(e.mem_byte));
            check_eq("is_branch", 32'(is_branch), 32'(e.is_branch));
            check_eq("is_jump",   32'(is_jump),   32'(e.is_jump));
            check_eq("alu_op",    32'(alu_op),    32'(e.alu_op));
            check_eq("alu_src_imm", 32'(alu_src_imm), 32'(e.src_imm));
            if (e.has_imm) check_eq("imm", imm, e.imm);
        end else begin
            check_eq("bubble_ctrl",
                     32'({reg_write, mem_read, mem_write, mem_byte,
                          is_branch, is_jump, illegal}), 32'd0);
        end
    endtask

    // ---------------------------------------------------------------- driver tasks
    task automatic drive(input logic vin, input logic [31:0] ins,
                         input logic [31:0] pc, input logic stall,
                         input logic flush);
        valid_in     = vin;
        instr_in     = ins;
        pc_in        = pc;
        stall_decode = stall;
        flush_decode = flush;
    endtask

    task automatic drive_wb(input logic en, input logic [4:0] r,
                            input logic [31:0] d);
        wb_en   = en;
        wb_rd   = r;
        wb_data = d;
    endtask

    // Inputs change 1 time unit after an edge; outputs are checked 1 unit
    // after the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] r2,
                                           input logic [4:0] r1, input logic [4:0] d);
        return {f7, r2, r1, 3'b000, d, 7'b0110011};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [6:0]  ops [6];
        ops[0] = 7'h33; ops[1] = 7'h13; ops[2] = 7'h03;
        ops[3] = 7'h23; ops[4] = 7'h63; ops[5] = 7'h6f;
        r = $urandom;
        case ($urandom_range(0, 9))
            0: r = r_type(7'h00, r[24:20], r[19:15], r[11:7]);
            1: r = r_type(7'h20, r[24:20], r[19:15], r[11:7]);
            2: r = r_type(7'h01, r[24:20], r[19:15], r[11:7]);
            3: r = {r[31:15], 3'b000, r[11:7], 7'h13};
            4: r = {r[31:15], ($urandom_range(0, 1) != 0) ? 3'b010 : 3'b000, r[11:7], 7'h03};
            5: r = {r[31:15], ($urandom_range(0, 1) != 0) ? 3'b010 : 3'b000, r[11:7], 7'h23};
            6: r = {r[31:15], 3'b000, r[11:7], 7'h63};
            7: r = {r[31:7], 7'h6f};
            8: r = {r[31:7], ops[$urandom_range(0, 5)]};  // often bad funct fields
            default: ;                                     // raw random word
        endcase
        return r;
    endfunction

    // ---------------------------------------------------------------- stimulus
    initial begin
        logic [31:0] add_x3, lw_x4, add_x7;
        model_reset();
        #1 reset = 1'b0;
        #1;
        check_outputs();
        check_eq("reset_pc", pc_out, 32'h0000_1000);
        @(posedge clk); #1;
        reset = 1'b1;

        // Bubbles after reset: every rs1 index reads 0.
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, r_type(7'h00, 5'(31 - i), 5'(i), 5'd1), PC_BOOT, 1'b0, 1'b0);
            tick();
            check_eq("boot_rs1_zero", rs1_data, 32'd0);
        end
        check_eq("boot_pc", pc_out, 32'h0000_1000);

        // Write x5, then ADD x3,x5,x5.
        drive_wb(1'b1, 5'd5, 32'hDEAD_BEEF);
        tick();
        drive_wb(1'b0, 5'd0, 32'd0);
        add_x3 = r_type(7'h00, 5'd5, 5'd5, 5'd3);
        drive(1'b1, add_x3, 32'h0000_1004, 1'b0, 1'b0);
        tick();
        check_eq("add_rd", 32'(rd), 32'd3);
        check_eq("add_rs1_data", rs1_data, 32'hDEAD_BEEF);
        check_eq("add_rs2_data", rs2_data, 32'hDEAD_BEEF);
        check_eq("add_alu_op", 32'(alu_op), 32'd0);
        check_eq("add_reg_write", 32'(reg_write), 32'd1);

        // SW x2,-4(x1)
        drive(1'b1, 32'hFE20_AE23, 32'h0000_1008, 1'b0, 1'b0);
        tick();
        check_eq("sw_mem_write", 32'(mem_write), 32'd1);
        check_eq("sw_mem_byte", 32'(mem_byte), 32'd0);
        check_eq("sw_imm", imm, 32'hFFFF_FFFC);
        check_eq("sw_src_imm", 32'(alu_src_imm), 32'd1);
        check_eq("sw_reg_write", 32'(reg_write), 32'd0);

        // LW x4,8(x5), then stall three cycles with changing fetch data.
        lw_x4 = {12'd8, 5'd5, 3'b010, 5'd4, 7'b0000011};
        drive(1'b1, lw_x4, 32'h0000_100C, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, $urandom, $urandom, 1'b1, 1'b0);
            tick();
            check_eq("stall_pc", pc_out, 32'h0000_100C);
            check_eq("stall_mem_read", 32'(mem_read), 32'd1);
            check_eq("stall_imm", imm, 32'd8);
        end
        drive(1'b1, $urandom, $urandom, 1'b1, 1'b1);
        tick();
        check_eq("flush_valid", 32'(valid_out), 32'd0);
        check_eq("flush_mem_read", 32'(mem_read), 32'd0);
        check_eq("flush_pc_kept", pc_out, 32'h0000_100C);

        // Writes to x0 are dropped.
        drive_wb(1'b1, 5'd0, 32'd7);
        drive(1'b1, r_type(7'h00, 5'd0, 5'd0, 5'd9), 32'h0000_1010, 1'b0, 1'b0);
        tick();
        tick();
        check_eq("x0_read", rs1_data, 32'd0);
        drive_wb(1'b0, 5'd0, 32'd0);
        drive(1'b1, 32'hFFFF_FFFF, 32'h0000_1014, 1'b0, 1'b0);
        tick();
        check_eq("illegal_flag", 32'(illegal), 32'd1);
        check_eq("illegal_reg_write", 32'(reg_write), 32'd0);

        // Same-cycle write-back to a register being read.
        drive_wb(1'b1, 5'd7, 32'd1);
        tick();
        drive_wb(1'b0, 5'd0, 32'd0);
        add_x7 = r_type(7'h00, 5'd0, 5'd7, 5'd1);
        drive(1'b1, add_x7, 32'h0000_1018, 1'b0, 1'b0);
        tick();
        drive_wb(1'b1, 5'd7, 32'd42);
        #1;
`ifdef BRISC_RF_BYPASS_EN
        check_eq("bypass_same_cycle", rs1_data, 32'd42);
`else
        check_eq("nobypass_same_cycle", rs1_data, 32'd1);
`endif
        tick();
        drive_wb(1'b0, 5'd0, 32'd0);
        #1;
        check_eq("after_write_edge", rs1_data, 32'd42);

        // Asynchronous reset mid-cycle clears everything without an edge.
        #2 reset = 1'b0;
        #1;
        check_outputs();
        check_eq("async_rst_valid", 32'(valid_out), 32'd0);
        check_eq("async_rst_pc", pc_out, PC_BOOT);
        @(posedge clk); #1;
        reset = 1'b1;
        drive(1'b1, add_x7, 32'h0000_2000, 1'b0, 1'b0);
        tick();
        check_eq("async_rst_rf_cleared", rs1_data, 32'd0);

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            drive($urandom_range(0, 3) != 0, rand_instr(), $urandom,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
            drive_wb($urandom_range(0, 1) != 0, 5'($urandom_range(0, 31)), $urandom);
            #1;
            check_outputs();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global time limit so the run always ends on its own.
    initial begin
        #200000;
        n_err++;
        $display("FAIL timeout: simulation did not complete");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Second pipeline stage, directly downstream of instruction fetch.
- Holds the IF/ID pipeline register, decodes the brisc instruction subset, and reads operands from the 32-entry register file it owns.
- Accepts write-back from the last stage.
- Drives decoded control and operands to execute; responds to stall and flush from the hazard/branch logic.

Parameters:
- XLEN, 32, data/PC width.
- NUM_REGS, 32, architectural registers; x0 hardwired to zero.
- PC_BOOT, 32'h0000_1000, pc_out value while the stage holds a bubble after reset.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- stall_decode  in  1  hold IF/ID register contents
- flush_decode  in  1  replace IF/ID contents with a bubble (taken branch/jump)
- valid_in  in  1  fetch presents a valid instruction (low on I-cache miss)
- instr_in  in  32  instruction from fetch
- pc_in  in  XLEN  PC of instr_in
- wb_en  in  1  register-file write enable
- wb_rd  in  5  write-back destination
- wb_data  in  XLEN  write-back data
- valid_out  out  1  decoded instruction valid
- pc_out  out  XLEN  PC of decoded instruction
- rs1, rs2, rd  out  5 each  register indices
- rs1_data, rs2_data  out  XLEN  operand values
- imm  out  XLEN  sign-extended immediate
- alu_op  out  2  0=ADD, 1=SUB, 2=MUL
- alu_src_imm  out  1  operand B is imm
- reg_write, mem_read, mem_write, mem_byte, is_branch, is_jump  out  1 each  control
- illegal  out  1  valid instruction with unsupported encoding

Behaviour:
- IF/ID register fields: valid, instr, pc.
- Update priority per rising edge: reset > flush_decode > stall_decode > load.
  - reset low (async): valid=0, instr=32'h0000_0013 (NOP), pc=PC_BOOT; all register-file entries cleared to 0.
  - flush_decode=1: valid=0, instr=NOP; pc unchanged. Flush wins over a simultaneous stall.
  - stall_decode=1 (no flush): all fields hold; valid_in/instr_in ignored.
  - Otherwise: valid<=valid_in, instr<=instr_in, pc<=pc_in.
- Latency: an instruction captured at edge N appears decoded on the outputs from edge N until the next update. Decode and register read are combinational from IF/ID.
- When valid=0, all control outputs are forced to 0 (reg_write, mem_*, is_*, illegal). valid_out=0.
- Decode table (opcode/funct3/funct7):
  - 0110011, f3=000, f7=0000000: ADD. reg_write=1.
  - 0110011, f3=000, f7=0100000: SUB. reg_write=1.
  - 0110011, f3=000, f7=0000001: MUL. reg_write=1.
  - 0010011, f3=000: ADDI. I-imm, alu_src_imm=1, reg_write=1.
  - 0000011, f3=000 (LB) or 010 (LW): mem_read=1, reg_write=1, alu_src_imm=1, I-imm. mem_byte=1 for LB.
  - 0100011, f3=000 (SB) or 010 (SW): mem_write=1, alu_src_imm=1, S-imm. mem_byte=1 for SB.
  - 1100011, f3=000: BEQ. is_branch=1, alu_op=SUB, B-imm.
  - 1101111: JAL. is_jump=1, reg_write=1, J-imm.
  - Any other encoding: illegal=1, all other control 0.
- Immediates: sign-extended from instr[31]. B-imm and J-imm have bit0=0.
- rd output: instr[11:7] for all formats. Consumers qualify it with reg_write.
- Register file:
  - Write on rising edge when wb_en=1 and wb_rd!=0.
  - Writes to x0 are ignored; reads of x0 return 0.
  - Writes are independent of stall/flush.
- Reset mid-operation clears IF/ID and the register file immediately, without waiting for a clock edge.

Optional Feature:
- Macro: BRISC_RF_BYPASS_EN.
- Defined: when wb_en=1, wb_rd!=0 and wb_rd equals rs1 (or rs2) in the same cycle, rs1_data (or rs2_data) returns wb_data combinationally.
- Undefined: reads return the stored value. The new value is visible from the cycle after the write edge, and hazard logic must stall one extra cycle.

Test Plan:
- Reset release, then hold valid_in=0 -> valid_out=0, pc_out=32'h1000, all control 0, rs1_data=0 for every rs1.
- wb_en=1, wb_rd=5, wb_data=32'hDEAD_BEEF; then load ADD x3,x5,x5 at pc 32'h1004 -> next cycle rd=3, rs1_data=rs2_data=32'hDEADBEEF, alu_op=0, reg_write=1.
- Load SW x2,-4(x1) (instr 32'hFE20AE23) -> mem_write=1, mem_byte=0, imm=32'hFFFF_FFFC, alu_src_imm=1, reg_write=0.
- Capture LW; hold stall_decode=1 for 3 cycles while instr_in changes -> outputs unchanged. Assert flush_decode together with stall -> next cycle valid_out=0, controls 0.
- wb_en=1, wb_rd=0, wb_data=7 -> rs1_data for rs1=0 stays 0. Load instr 32'hFFFF_FFFF -> illegal=1, reg_write=0.
- With BRISC_RF_BYPASS_EN: rs1=7 decoded while wb_rd=7, wb_data=42 -> rs1_data=42 in the same cycle. Without the macro -> old value in that cycle, 42 in the next cycle.
